// File: rtl/csa_cpa_pipe_if.sv
// rtl/csa_cpa_pipe_if.sv - carry-save input / binary result stream bundle for csa_cpa_pipe
interface csa_cpa_pipe_if #(
    parameter int W = 41
);
    logic [W-1:0] in_c;
    logic [W-1:0] in_s;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   out_sum;
    logic         out_valid;
    logic         out_ready;

    // Producer of carry-save pairs and consumer of results
    modport master (
        output in_c, in_s, in_valid, out_ready,
        input  in_ready, out_sum, out_valid
    );

    // The resolver pipeline itself
    modport slave (
        input  in_c, in_s, in_valid, out_ready,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/csa_cpa_pipe.sv
// rtl/csa_cpa_pipe.sv - segmented ripple pipeline resolving a carry-save pair to binary
module csa_cpa_pipe #(
    parameter int W   = 41,
    parameter int SEG = 14
) (
    input  logic          clk,
    input  logic          rst,
    csa_cpa_pipe_if.slave bus
);
    localparam int NSEG = (W + SEG - 1) / SEG;

    // Stage k registers: resolved low bits, carry out of its segment, valid.
    // Stages 0..NSEG-2 also skew the still-unresolved c/s bits forward.
    logic [W-1:0]    c_q  [NSEG-1];
    logic [W-1:0]    s_q  [NSEG-1];
    logic [W-1:0]    r_q  [NSEG];
    logic [NSEG-1:0] cy_q;
    logic [NSEG-1:0] v_q;

    // Stage k inputs (from the bus for stage 0, from stage k-1 otherwise)
    logic [W-1:0]    c_src [NSEG];
    logic [W-1:0]    s_src [NSEG];
    logic [W-1:0]    r_src [NSEG];
    logic [NSEG-1:0] cy_src;
    logic [NSEG-1:0] v_src;

    // Next-state of resolved bits and segment carries
    logic [W-1:0]    r_d  [NSEG];
    logic [NSEG-1:0] cy_d;
    logic            carry;

    logic            en;

    // Whole pipeline advances together; it only stalls when a result is stuck at the output
    assign en            = !v_q[NSEG-1] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[NSEG-1];
    assign bus.out_sum   = {cy_q[NSEG-1], r_q[NSEG-1]};

    // Route each stage's inputs: stage 0 from the bus with zero carry-in, others from the previous stage
    always_comb begin
        c_src[0]  = bus.in_c;
        s_src[0]  = bus.in_s;
        r_src[0]  = '0;
        cy_src[0] = 1'b0;
        v_src[0]  = bus.in_valid;
        for (int k = 1; k < NSEG; k++) begin
            c_src[k]  = c_q[k-1];
            s_src[k]  = s_q[k-1];
            r_src[k]  = r_q[k-1];
            cy_src[k] = cy_q[k-1];
            v_src[k]  = v_q[k-1];
        end
    end

    // Ripple-add the bits of segment k only; the last segment may be narrower than SEG
    always_comb begin
        carry = 1'b0;
        cy_d  = '0;
        for (int k = 0; k < NSEG; k++) begin
            r_d[k] = r_src[k];
            carry  = cy_src[k];
            for (int i = 0; i < W; i++) begin
                if (i / SEG == k) begin
                    r_d[k][i] = c_src[k][i] ^ s_src[k][i] ^ carry;
                    carry     = (c_src[k][i] & s_src[k][i]) | (carry & (c_src[k][i] ^ s_src[k][i]));
                end
            end
            cy_d[k] = carry;
        end
    end

    // Pipeline registers: clear on reset, shift by one stage whenever enabled, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            cy_q <= '0;
            for (int k = 0; k < NSEG; k++) begin
                r_q[k] <= '0;
            end
            for (int k = 0; k < NSEG - 1; k++) begin
                c_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q  <= v_src;
            cy_q <= cy_d;
            for (int k = 0; k < NSEG; k++) begin
                r_q[k] <= r_d[k];
            end
            for (int k = 0; k < NSEG - 1; k++) begin
                c_q[k] <= c_src[k];
                s_q[k] <= s_src[k];
            end
        end
    end
endmodule
